// File: rtl/nav_key_pkg.sv
// Shared definitions for the navigation key conditioning block.
// Key indices follow the board pin order KEY1..KEY5.
package nav_key_pkg;

    localparam int NAV_KEY_NUM          = 5;
    localparam int NAV_KEY_DEBOUNCE_SIM = 16;

    typedef enum logic [2:0] {
        UP     = 3'd0,
        DOWN   = 3'd1,
        LEFT   = 3'd2,
        RIGHT  = 3'd3,
        CENTER = 3'd4
    } nav_key_idx_t;

    // Pin level that means "pressed".
    function automatic logic nav_key_active_level(input int active_low);
        return (active_low != 0) ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/nav_key_channel.sv
// One key: synchroniser, stability counter, debounced level and edge pulses.
// All outputs are registered; nothing from key_i reaches an output combinationally.
module nav_key_channel
    import nav_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic key_i,
    output logic debounced_o,
    output logic pressed_o,
    output logic released_o
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           ACT     = nav_key_active_level(ACTIVE_LOW);
    localparam logic           IDLE    = ~ACT;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   pressed_q, pressed_d;
    logic                   released_q, released_d;
    logic                   synced;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], key_i};
    assign synced = sync_q[SYNC_STAGES-1];

    // Any cycle that agrees with the stable level restarts the count.
    always_comb begin
        cnt_d      = '0;
        stable_d   = stable_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d   = synced;
                pressed_d  = (synced == ACT);
                released_d = (synced != ACT);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sync_q     <= {SYNC_STAGES{IDLE}};
            cnt_q      <= '0;
            stable_q   <= IDLE;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign debounced_o = stable_q;
    assign pressed_o   = pressed_q;
    assign released_o  = released_q;

endmodule

// File: rtl/nav_key_debounce.sv
// Five-way navigation switch conditioning: per-key debounce channels plus
// sticky press flags (write-1-to-clear) and a registered level interrupt.
module nav_key_debounce
    import nav_key_pkg::*;
#(
    parameter int NUM_KEYS        = NAV_KEY_NUM,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic [NUM_KEYS-1:0] keys_in,
    input  logic [NUM_KEYS-1:0] event_clear,
    output logic [NUM_KEYS-1:0] keys_debounced,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_released,
    output logic [NUM_KEYS-1:0] event_pending,
    output logic                int_out
);

    logic [NUM_KEYS-1:0] pend_q, pend_d;
    logic                int_q, int_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        nav_key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .sync_reset  (sync_reset),
            .key_i       (keys_in[i]),
            .debounced_o (keys_debounced[i]),
            .pressed_o   (key_pressed[i]),
            .released_o  (key_released[i])
        );
    end

    // A press arriving with its own clear still leaves the flag set.
    assign pend_d = (pend_q & ~event_clear) | key_pressed;
    assign int_d  = |pend_q;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pend_q <= '0;
            int_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            int_q  <= int_d;
        end
    end

    assign event_pending = pend_q;
    assign int_out       = int_q;

endmodule
